// File: rtl/bcd_frame_ctrl_pkg.sv
// Shared types and constants for the serial BCD operand frame loader.
package bcd_frame_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StHold
  } state_e;

  localparam int unsigned NDIG_DEFAULT = 4;
  localparam logic [3:0]  BCD_MAX      = 4'd9;

  function automatic int unsigned frame_bits(input int unsigned ndig);
    return 8 * ndig;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned ndig);
    return $clog2(8 * ndig);
  endfunction

  localparam int unsigned FRAME_BITS = frame_bits(NDIG_DEFAULT);
  localparam int unsigned CNT_W      = cnt_w(NDIG_DEFAULT);

endpackage

// File: rtl/bcd_frame_ctrl_nibble_check.sv
// Flags a frame image in which any 4-bit nibble holds a non-BCD value (> 9).
module bcd_nibble_check
  import bcd_frame_ctrl_pkg::*;
#(
  parameter int unsigned NDIG = 4
) (
  input  logic [8*NDIG-1:0] data_i,
  output logic              err_o
);

  always_comb begin
    err_o = 1'b0;
    for (int i = 0; i < 2 * NDIG; i++) begin
      if (data_i[4*i +: 4] > BCD_MAX) begin
        err_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bcd_frame_ctrl.sv
// Serial BCD operand loader: start-bit detect, one-frame shift-in, valid/ready hand-off.
module bcd_frame_ctrl
  import bcd_frame_ctrl_pkg::*;
#(
  parameter int unsigned NDIG = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in,
  output logic              busy,
  output logic [4*NDIG-1:0] a_bcd,
  output logic [4*NDIG-1:0] b_bcd,
  output logic              bcd_err,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int unsigned          FrameBits = frame_bits(NDIG);
  localparam int unsigned          CntW      = cnt_w(NDIG);
  localparam logic [CntW-1:0]      LastCnt   = CntW'(FrameBits - 1);

  state_e                 state_q;
  logic [CntW-1:0]        cnt_q;
  // The newest bit arrives straight from `in`, so only FrameBits-1 bits need storing;
  // the full right-shifted image is {in, shreg_q}.
  logic [FrameBits-2:0]   shreg_q;
  logic [FrameBits-1:0]   frame_d;
  logic                   err_d;
  logic [4*NDIG-1:0]      a_q, b_q;
  logic                   err_q, valid_q, busy_q;

  assign frame_d = {in, shreg_q};

  bcd_nibble_check #(
    .NDIG(NDIG)
  ) u_check (
    .data_i(frame_d),
    .err_o (err_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      shreg_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in) begin
            state_q <= StShift;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        StShift: begin
          shreg_q <= frame_d[FrameBits-1:1];
          if (cnt_q == LastCnt) begin
            {b_q, a_q} <= frame_d;
            err_q      <= err_d;
            valid_q    <= 1'b1;
            cnt_q      <= '0;
            state_q    <= StHold;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StHold: begin
          // Serial input is dropped here; the sender must watch busy.
          if (out_ready) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy      = busy_q;
  assign a_bcd     = a_q;
  assign b_bcd     = b_q;
  assign bcd_err   = err_q;
  assign out_valid = valid_q;

endmodule
